// File: rtl/snake_pkg.sv
// Shared definitions for the snake coordinate bus: cell codes, scan states,
// segment bit layout and small coordinate helpers.
package snake_pkg;

    // Segment layout on the packed bus, MSB first within each 16-bit slot.
    localparam int SEG_W = 16;
    localparam int X_OFS = 0;
    localparam int Y_OFS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_BODY  = 2'b01,
        CELL_HEAD  = 2'b10,
        CELL_FOOD  = 2'b11
    } cell_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } xy_t;

    function automatic xy_t seg_unpack(input logic [SEG_W-1:0] s);
        xy_t r;
        r.x = s[SEG_W-1-X_OFS -: 8];
        r.y = s[SEG_W-1-Y_OFS -: 8];
        return r;
    endfunction

    function automatic logic in_field(input xy_t p, input int sx, input int sy);
        return (int'(p.x) < sx) && (int'(p.y) < sy);
    endfunction

    function automatic int cell_idx(input xy_t p, input int sx);
        return int'(p.y) * sx + int'(p.x);
    endfunction

endpackage

// File: rtl/snake_cell_query.sv
// Registered lookup of the front occupancy buffer, priority head > body > food > empty.
// Latency 1 cycle (q_rdy follows q_valid); no backpressure, one query per cycle.
module snake_cell_query
    import snake_pkg::*;
#(
    parameter int SIZE_X = 10,
    parameter int SIZE_Y = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       q_valid,
    input  logic [7:0]                 q_x,
    input  logic [7:0]                 q_y,
    input  logic [SIZE_X*SIZE_Y-1:0]   front,
    input  xy_t                        head,
    input  xy_t                        food,
    input  logic                       food_vld,
    output logic [1:0]                 q_cell,
    output logic                       q_rdy
);

    localparam int CELLS = SIZE_X * SIZE_Y;
    localparam int IW    = $clog2(CELLS);

    xy_t            q_pt;
    logic [IW-1:0]  q_idx;
    cell_t          cell_nx;

    always_comb begin
        q_pt    = {q_x, q_y};
        q_idx   = IW'(cell_idx(q_pt, SIZE_X));
        cell_nx = CELL_EMPTY;
        // The head is always marked in the bitmap when in field, so occupancy gates it.
        if (in_field(q_pt, SIZE_X, SIZE_Y)) begin
            if (front[q_idx]) begin
                cell_nx = (q_pt == head) ? CELL_HEAD : CELL_BODY;
            end else if (food_vld && (q_pt == food)) begin
                cell_nx = CELL_FOOD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_rdy  <= 1'b0;
            q_cell <= CELL_EMPTY;
        end else begin
            q_rdy <= q_valid;
            if (q_valid) begin
                q_cell <= cell_nx;
            end
        end
    end

endmodule

// File: rtl/snake_field_reader.sv
// Snapshots the snake bus on step, walks one segment per clock, commits flags and bitmap.
// Latency len_eff+2 cycles from step to done; step while busy is dropped, queries never stall.
module snake_field_reader
    import snake_pkg::*;
#(
    parameter int SIZE_X = 10,
    parameter int SIZE_Y = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 step,
    input  logic [15:0]                          lengh,
    input  logic [0:SEG_W*SIZE_X*SIZE_Y-1]       snake_xy,
    input  logic [7:0]                           food_x,
    input  logic [7:0]                           food_y,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 grow,
    output logic                                 wall_hit,
    output logic                                 self_hit,
    output logic                                 game_over,
    input  logic                                 q_valid,
    input  logic [7:0]                           q_x,
    input  logic [7:0]                           q_y,
    output logic [1:0]                           q_cell,
    output logic                                 q_rdy
);

    localparam int          CELLS   = SIZE_X * SIZE_Y;
    localparam int          IW      = $clog2(CELLS);
    localparam int          SW      = $clog2(SEG_W * CELLS);
    localparam logic [15:0] CELLS16 = 16'(CELLS);

    state_t                    state, state_nx;
    logic                      accept;
    logic                      scan_last;
    logic [15:0]               len_clamp;
    logic [15:0]               len_eff_r;
    logic [15:0]               k;
    logic [0:SEG_W*CELLS-1]    snap;
    logic [SW-1:0]             seg_base;
    xy_t                       seg;
    logic                      seg_in;
    logic [IW-1:0]             seg_idx;

    xy_t                       head_r, food_r, front_head, front_food;
    logic                      front_vld;
    logic [CELLS-1:0]          back, front;
    logic                      wall_n, self_n, food_n;

    always_comb begin
        len_clamp = (lengh > CELLS16) ? CELLS16 : lengh;
        scan_last = (k == len_eff_r - 16'd1);
        seg_base  = SW'(int'(k[IW-1:0]) * SEG_W);
        seg       = seg_unpack(snap[seg_base +: SEG_W]);
        seg_in    = in_field(seg, SIZE_X, SIZE_Y);
        seg_idx   = IW'(cell_idx(seg, SIZE_X));
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (step) begin
                    accept   = 1'b1;
                    state_nx = (len_clamp != 16'd0) ? ST_SCAN : ST_COMMIT;
                end
            end
            ST_SCAN: begin
                if (scan_last) begin
                    state_nx = ST_COMMIT;
                end
            end
            ST_COMMIT: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || start) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The snapshot holds whatever was last latched; only k..len_eff-1 are ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            snap <= snake_xy;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || start) begin
            k          <= '0;
            len_eff_r  <= '0;
            back       <= '0;
            front      <= '0;
            head_r     <= '0;
            food_r     <= '0;
            front_head <= '0;
            front_food <= '0;
            front_vld  <= 1'b0;
            wall_n     <= 1'b0;
            self_n     <= 1'b0;
            food_n     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            grow       <= 1'b0;
            wall_hit   <= 1'b0;
            self_hit   <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            done <= 1'b0;
            grow <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        len_eff_r <= len_clamp;
                        food_r    <= {food_x, food_y};
                        back      <= '0;
                        k         <= '0;
                        wall_n    <= 1'b0;
                        self_n    <= 1'b0;
                        food_n    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (k == 16'd0) begin
                        head_r <= seg;
                        wall_n <= !seg_in;
                        food_n <= (seg == food_r);
                    end else begin
                        self_n <= self_n | (seg == head_r);
                    end
                    if (seg_in) begin
                        back[seg_idx] <= 1'b1;
                    end
                    k <= k + 16'd1;
                end
                ST_COMMIT: begin
                    front      <= back;
                    front_head <= head_r;
                    front_food <= food_r;
                    front_vld  <= 1'b1;
                    wall_hit   <= wall_n;
                    self_hit   <= self_n;
                    game_over  <= game_over | wall_n | self_n;
                    grow       <= food_n & ~wall_n;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    snake_cell_query #(
        .SIZE_X (SIZE_X),
        .SIZE_Y (SIZE_Y)
    ) u_query (
        .clk      (clk),
        .rst      (rst),
        .q_valid  (q_valid),
        .q_x      (q_x),
        .q_y      (q_y),
        .front    (front),
        .head     (front_head),
        .food     (front_food),
        .food_vld (front_vld),
        .q_cell   (q_cell),
        .q_rdy    (q_rdy)
    );

endmodule

// File: tb/tb_snake_field_reader.sv
// Directed bench for snake_field_reader on a 10x10 field: frame table plus corner-case sequences.
module tb_snake_field_reader;

    localparam int SX    = 10;
    localparam int SY    = 10;
    localparam int CELLS = SX * SY;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     step;
    logic [15:0]              lengh;
    logic [0:16*CELLS-1]      snake_xy;
    logic [7:0]               food_x, food_y;
    logic                     busy, done, grow, wall_hit, self_hit, game_over;
    logic                     q_valid;
    logic [7:0]               q_x, q_y;
    logic [1:0]               q_cell;
    logic                     q_rdy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [47:0] xs;
        logic [47:0] ys;
        logic [15:0] len;
        logic [7:0]  fx, fy;
        logic        e_wall, e_self, e_grow, e_go;
        logic [7:0]  qx0, qy0;
        logic [1:0]  qe0;
        logic [7:0]  qx1, qy1;
        logic [1:0]  qe1;
    } vec_t;

    vec_t tbl [6];

    snake_field_reader #(.SIZE_X(SX), .SIZE_Y(SY)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step      (step),
        .lengh     (lengh),
        .snake_xy  (snake_xy),
        .food_x    (food_x),
        .food_y    (food_y),
        .busy      (busy),
        .done      (done),
        .grow      (grow),
        .wall_hit  (wall_hit),
        .self_hit  (self_hit),
        .game_over (game_over),
        .q_valid   (q_valid),
        .q_x       (q_x),
        .q_y       (q_y),
        .q_cell    (q_cell),
        .q_rdy     (q_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic query(input logic [7:0] x, input logic [7:0] y, input logic [1:0] exp, input string nm);
        q_valid = 1'b1;
        q_x     = x;
        q_y     = y;
        tick();
        q_valid = 1'b0;
        chk({nm, "_rdy"}, 32'(q_rdy), 32'd1);
        chk(nm, 32'(q_cell), 32'(exp));
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        int cyc;
        int lat;
        logic busy_ok;
        snake_xy = '0;
        for (int i = 0; i < 6; i++) begin
            snake_xy[16*i +: 8]   = v.xs[8*i +: 8];
            snake_xy[16*i+8 +: 8] = v.ys[8*i +: 8];
        end
        lengh  = v.len;
        food_x = v.fx;
        food_y = v.fy;
        step   = 1'b1;
        tick();
        step    = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 300) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        lat = ((v.len > 16'd100) ? 100 : int'(v.len)) + 2;
        chk({nm, "_latency"}, 32'(cyc), 32'(lat));
        chk({nm, "_busy_during"}, 32'(busy_ok), 32'd1);
        chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({nm, "_wall"}, 32'(wall_hit), 32'(v.e_wall));
        chk({nm, "_self"}, 32'(self_hit), 32'(v.e_self));
        chk({nm, "_grow"}, 32'(grow), 32'(v.e_grow));
        chk({nm, "_game_over"}, 32'(game_over), 32'(v.e_go));
        query(v.qx0, v.qy0, v.qe0, {nm, "_q0"});
        query(v.qx1, v.qy1, v.qe1, {nm, "_q1"});
    endtask

    initial begin
        int dcount;
        int dcyc;
        int cyc;

        // seg0 in the lowest byte of xs/ys
        tbl[0] = '{xs: {8'd0, 8'd0, 8'd254, 8'd255, 8'd0, 8'd1}, ys: 48'd0, len: 16'd4,
                   fx: 8'd5, fy: 8'd5, e_wall: 1'b0, e_self: 1'b0, e_grow: 1'b0, e_go: 1'b0,
                   qx0: 8'd1, qy0: 8'd0, qe0: 2'b10, qx1: 8'd0, qy1: 8'd0, qe1: 2'b01};
        tbl[1] = '{xs: {8'd0, 8'd0, 8'd0, 8'd2, 8'd3, 8'd4}, ys: {8'd0, 8'd0, 8'd0, 8'd4, 8'd4, 8'd4},
                   len: 16'd3, fx: 8'd4, fy: 8'd4, e_wall: 1'b0, e_self: 1'b0, e_grow: 1'b1, e_go: 1'b0,
                   qx0: 8'd4, qy0: 8'd4, qe0: 2'b10, qx1: 8'd3, qy1: 8'd4, qe1: 2'b01};
        tbl[2] = '{xs: {8'd0, 8'd2, 8'd2, 8'd3, 8'd3, 8'd2}, ys: {8'd0, 8'd2, 8'd3, 8'd3, 8'd2, 8'd2},
                   len: 16'd5, fx: 8'd9, fy: 8'd9, e_wall: 1'b0, e_self: 1'b1, e_grow: 1'b0, e_go: 1'b1,
                   qx0: 8'd2, qy0: 8'd2, qe0: 2'b10, qx1: 8'd3, qy1: 8'd3, qe1: 2'b01};
        tbl[3] = '{xs: {8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd5}, ys: {8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd5},
                   len: 16'd2, fx: 8'd0, fy: 8'd0, e_wall: 1'b0, e_self: 1'b0, e_grow: 1'b0, e_go: 1'b1,
                   qx0: 8'd5, qy0: 8'd5, qe0: 2'b10, qx1: 8'd2, qy1: 8'd2, qe1: 2'b00};
        tbl[4] = '{xs: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255}, ys: {8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd3},
                   len: 16'd2, fx: 8'd255, fy: 8'd3, e_wall: 1'b1, e_self: 1'b0, e_grow: 1'b0, e_go: 1'b1,
                   qx0: 8'd255, qy0: 8'd3, qe0: 2'b00, qx1: 8'd0, qy1: 8'd3, qe1: 2'b01};
        tbl[5] = '{xs: 48'd0, ys: 48'd0, len: 16'd0, fx: 8'd7, fy: 8'd7,
                   e_wall: 1'b0, e_self: 1'b0, e_grow: 1'b0, e_go: 1'b1,
                   qx0: 8'd7, qy0: 8'd7, qe0: 2'b11, qx1: 8'd0, qy1: 8'd3, qe1: 2'b00};

        rst      = 1'b0;
        start    = 1'b0;
        step     = 1'b1;
        lengh    = 16'd4;
        snake_xy = '0;
        food_x   = 8'd0;
        food_y   = 8'd0;
        q_valid  = 1'b0;
        q_x      = 8'd0;
        q_y      = 8'd0;

        // Reset held with step asserted
        tick();
        chk("rst_busy_c1", 32'(busy), 32'd0);
        tick();
        chk("rst_busy_c2", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_grow", 32'(grow), 32'd0);
        chk("rst_wall", 32'(wall_hit), 32'd0);
        chk("rst_self", 32'(self_hit), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_q_rdy", 32'(q_rdy), 32'd0);
        chk("rst_q_cell", 32'(q_cell), 32'd0);
        rst  = 1'b1;
        step = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // start clears sticky state; query port keeps answering from the cleared buffer
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_game_over", 32'(game_over), 32'd0);
        chk("start_busy", 32'(busy), 32'd0);
        query(8'd7, 8'd7, 2'b00, "start_q_food_cleared");

        apply_vec(tbl[0], "replay0");
        query(8'd5, 8'd5, 2'b11, "replay0_q_food");
        query(8'd3, 8'd3, 2'b00, "replay0_q_empty");
        query(8'd255, 8'd0, 2'b00, "replay0_q_outside");

        // Full-field snake with lengh=500: clamps to 100, mid-scan step and queries
        for (int i = 0; i < CELLS; i++) begin
            snake_xy[16*i +: 8]   = 8'(i % 10);
            snake_xy[16*i+8 +: 8] = 8'(i / 10);
        end
        lengh  = 16'd500;
        food_x = 8'd200;
        food_y = 8'd200;
        step   = 1'b1;
        tick();
        step   = 1'b0;
        dcount = 0;
        dcyc   = 0;
        for (cyc = 1; cyc < 115; cyc++) begin
            if (done) begin
                dcount++;
                dcyc = cyc;
            end
            if (cyc == 5) chk("scan_q_old_head", 32'(q_cell), 32'd2);
            if (cyc == 7) chk("scan_q_old_food", 32'(q_cell), 32'd3);
            step    = (cyc == 3);
            q_valid = (cyc == 4) || (cyc == 6);
            q_x     = (cyc == 4) ? 8'd1 : 8'd5;
            q_y     = (cyc == 4) ? 8'd0 : 8'd5;
            tick();
        end
        step    = 1'b0;
        q_valid = 1'b0;
        chk("clamp_done_count", 32'(dcount), 32'd1);
        chk("clamp_latency", 32'(dcyc), 32'd102);
        chk("clamp_self", 32'(self_hit), 32'd0);
        chk("clamp_game_over", 32'(game_over), 32'd0);
        query(8'd9, 8'd9, 2'b01, "clamp_q_last_seg");
        query(8'd0, 8'd0, 2'b10, "clamp_q_head");
        query(8'd5, 8'd5, 2'b01, "clamp_q_body");

        // Reset in the middle of a self-collision scan
        apply_vec(tbl[1], "pre_abort");
        for (int i = 0; i < 6; i++) begin
            snake_xy[16*i +: 8]   = tbl[2].xs[8*i +: 8];
            snake_xy[16*i+8 +: 8] = tbl[2].ys[8*i +: 8];
        end
        lengh = 16'd5;
        step  = 1'b1;
        tick();
        step = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dcount++;
            tick();
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        chk("abort_self", 32'(self_hit), 32'd0);
        chk("abort_game_over", 32'(game_over), 32'd0);
        query(8'd4, 8'd4, 2'b00, "abort_q_cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
